// File: rtl/fl_chan_regfile_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fl_chan_regfile_if                                                       |
// | FPGALink channel bus: 7-bit channel select plus h2f/f2h byte streams.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface fl_chan_regfile_if;
  logic [6:0] chanAddr_in;
  logic [7:0] h2fData_in;
  logic       h2fValid_in;
  logic       h2fReady_out;
  logic [7:0] f2hData_out;
  logic       f2hValid_out;
  logic       f2hReady_in;

  // Comms block side
  modport master (
    output chanAddr_in,
    output h2fData_in,
    output h2fValid_in,
    input  h2fReady_out,
    input  f2hData_out,
    input  f2hValid_out,
    output f2hReady_in
  );

  // Application side
  modport slave (
    input  chanAddr_in,
    input  h2fData_in,
    input  h2fValid_in,
    output h2fReady_out,
    output f2hData_out,
    output f2hValid_out,
    input  f2hReady_in
  );
endinterface
`default_nettype wire

// File: rtl/fl_chan_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fl_chan_regfile                                                          |
// | FPGALink channel consumer: byte registers, loopback FIFO, status/flush.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fl_chan_regfile #(
  parameter int NUM_REGS    = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int FIFO_CHAN   = 8,
  parameter int STATUS_CHAN = 9
) (
  input  wire logic              clk_in,
  input  wire logic              reset_in,
  fl_chan_regfile_if.slave       chan,
  output logic [NUM_REGS*8-1:0]  regs_out
);

  localparam int               c_ptr_w       = $clog2(FIFO_DEPTH);
  localparam int               c_cnt_w       = c_ptr_w + 1;
  localparam logic [7:0]       c_num_regs    = 8'(NUM_REGS);
  localparam logic [6:0]       c_fifo_chan   = 7'(FIFO_CHAN);
  localparam logic [6:0]       c_status_chan = 7'(STATUS_CHAN);
  localparam logic [c_cnt_w-1:0] c_depth     = c_cnt_w'(FIFO_DEPTH);

  logic [6:0]         addr_q, addr_d;
  logic [7:0]         regs_q [NUM_REGS];
  logic [7:0]         regs_d [NUM_REGS];
  logic [7:0]         fifo_mem_q [FIFO_DEPTH];
  logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_cnt_w-1:0] count_q, count_d;

  logic       w_blank;
  logic       w_active;
  logic       w_is_reg;
  logic       w_is_fifo;
  logic       w_is_status;
  logic       w_fifo_full;
  logic       w_h2f_ready;
  logic       w_f2h_valid;
  logic [7:0] w_f2h_data;
  logic [7:0] w_reg_rd_data;
  logic [7:0] w_status_data;
  logic [8:0] w_count_ext;
  logic       w_wr;
  logic       w_rd;
  logic       w_push;
  logic       w_pop;
  logic       w_flush;

  // A channel change blanks the first cycle so stale data never handshakes.
  assign w_blank     = (chan.chanAddr_in != addr_q);
  assign w_active    = reset_in && !w_blank;
  assign w_is_reg    = ({1'b0, chan.chanAddr_in} < c_num_regs);
  assign w_is_fifo   = (chan.chanAddr_in == c_fifo_chan);
  assign w_is_status = (chan.chanAddr_in == c_status_chan);
  assign w_fifo_full = (count_q == c_depth);
  assign w_count_ext = 9'(count_q);
  assign w_status_data = (w_count_ext > 9'd255) ? 8'hFF : w_count_ext[7:0];

  always_comb begin
    w_reg_rd_data = 8'h00;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (chan.chanAddr_in == 7'(k)) begin
        w_reg_rd_data = regs_q[k];
      end
    end
  end

  always_comb begin
    w_h2f_ready = 1'b0;
    w_f2h_valid = 1'b0;
    w_f2h_data  = 8'h00;
    if (w_active) begin
      w_h2f_ready = w_is_fifo ? !w_fifo_full : 1'b1;
      if (w_is_reg) begin
        w_f2h_data  = w_reg_rd_data;
        w_f2h_valid = 1'b1;
      end else if (w_is_fifo) begin
        w_f2h_data  = fifo_mem_q[rd_ptr_q];
        w_f2h_valid = (count_q != '0);
      end else if (w_is_status) begin
        w_f2h_data  = w_status_data;
        w_f2h_valid = 1'b1;
      end
    end
  end

  assign chan.h2fReady_out = w_h2f_ready;
  assign chan.f2hValid_out = w_f2h_valid;
  assign chan.f2hData_out  = w_f2h_data;

  assign w_wr    = chan.h2fValid_in && w_h2f_ready;
  assign w_rd    = w_f2h_valid && chan.f2hReady_in;
  assign w_push  = w_wr && w_is_fifo;
  assign w_pop   = w_rd && w_is_fifo;
  assign w_flush = w_wr && w_is_status;

  always_comb begin
    addr_d = chan.chanAddr_in;
    regs_d = regs_q;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (w_wr && (chan.chanAddr_in == 7'(k))) begin
        regs_d[k] = chan.h2fData_in;
      end
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (w_flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      addr_q   <= 7'h7F;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= 8'h00;
      end
    end else begin
      addr_q   <= addr_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= regs_d[k];
      end
    end
  end

  // Storage only; occupancy is tracked by the reset pointers and count.
  always_ff @(posedge clk_in) begin
    if (w_push) begin
      fifo_mem_q[wr_ptr_q] <= chan.h2fData_in;
    end
  end

  generate
    for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_out
      assign regs_out[8*k +: 8] = regs_q[k];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fl_chan_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fl_chan_regfile                                                       |
// | Directed self-checking bench for fl_chan_regfile.                        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_fl_chan_regfile;

  logic        clk;
  logic        rst_n;
  logic [63:0] regs_out;
  int          n_vec;
  int          n_err;

  fl_chan_regfile_if bus ();

  fl_chan_regfile #(
    .NUM_REGS    (8),
    .FIFO_DEPTH  (16),
    .FIFO_CHAN   (8),
    .STATUS_CHAN (9)
  ) dut (
    .clk_in   (clk),
    .reset_in (rst_n),
    .chan     (bus),
    .regs_out (regs_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic select(input logic [6:0] a);
    bus.chanAddr_in = a;
    bus.h2fValid_in = 1'b0;
    bus.f2hReady_in = 1'b0;
    cycle();
  endtask

  task automatic push(input logic [7:0] d);
    bus.h2fData_in  = d;
    bus.h2fValid_in = 1'b1;
    cycle();
    bus.h2fValid_in = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    #3;
    n_vec++; if (bus.h2fReady_out !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b want 0", bus.h2fReady_out); end
    n_vec++; if (bus.f2hValid_out !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", bus.f2hValid_out); end
    n_vec++; if (bus.f2hData_out !== 8'h00) begin n_err++; $display("FAIL rst_data: got %h want 00", bus.f2hData_out); end
    n_vec++; if (regs_out !== 64'h0) begin n_err++; $display("FAIL rst_regs: got %h want 0", regs_out); end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    n_vec++; if (bus.h2fReady_out !== 1'b0) begin n_err++; $display("FAIL first_blank: got %b want 0", bus.h2fReady_out); end
    cycle();
    n_vec++; if (bus.h2fReady_out !== 1'b1) begin n_err++; $display("FAIL reg_ready: got %b want 1", bus.h2fReady_out); end
    n_vec++; if (bus.f2hValid_out !== 1'b1 || bus.f2hData_out !== 8'h00) begin n_err++; $display("FAIL reg3_init: got v=%b d=%h want v=1 d=00", bus.f2hValid_out, bus.f2hData_out); end
  endtask

  task automatic test_reg_rw();
    push(8'hA5);
    n_vec++; if (regs_out[31:24] !== 8'hA5) begin n_err++; $display("FAIL reg3_wr: got %h want a5", regs_out[31:24]); end
    n_vec++; if (bus.f2hData_out !== 8'hA5 || bus.f2hValid_out !== 1'b1) begin n_err++; $display("FAIL reg3_rd: got v=%b d=%h want v=1 d=a5", bus.f2hValid_out, bus.f2hData_out); end
    // write and read same register in one cycle
    bus.h2fData_in  = 8'h5A;
    bus.h2fValid_in = 1'b1;
    bus.f2hReady_in = 1'b1;
    #1;
    n_vec++; if (bus.f2hData_out !== 8'hA5) begin n_err++; $display("FAIL wr_rd_pre: got %h want a5", bus.f2hData_out); end
    cycle();
    bus.h2fValid_in = 1'b0;
    bus.f2hReady_in = 1'b0;
    #1;
    n_vec++; if (bus.f2hData_out !== 8'h5A) begin n_err++; $display("FAIL wr_rd_post: got %h want 5a", bus.f2hData_out); end
    // blanked first cycle on new channel blocks the write
    bus.chanAddr_in = 7'd5;
    bus.h2fData_in  = 8'hC3;
    bus.h2fValid_in = 1'b1;
    #1;
    n_vec++; if (bus.h2fReady_out !== 1'b0) begin n_err++; $display("FAIL blank_ready: got %b want 0", bus.h2fReady_out); end
    cycle();
    bus.h2fValid_in = 1'b0;
    #1;
    n_vec++; if (regs_out[47:40] !== 8'h00) begin n_err++; $display("FAIL blank_nowr: got %h want 00", regs_out[47:40]); end
    push(8'hC3);
    n_vec++; if (regs_out !== 64'h0000C3005A000000) begin n_err++; $display("FAIL regs_vec: got %h want 0000c3005a000000", regs_out); end
  endtask

  task automatic test_fifo_fill();
    select(7'd8);
    n_vec++; if (bus.f2hValid_out !== 1'b0) begin n_err++; $display("FAIL fifo_empty: got %b want 0", bus.f2hValid_out); end
    for (int i = 0; i < 16; i++) begin
      bus.h2fData_in  = 8'(i);
      bus.h2fValid_in = 1'b1;
      #1;
      n_vec++; if (bus.h2fReady_out !== 1'b1) begin n_err++; $display("FAIL fill_ready[%0d]: got %b want 1", i, bus.h2fReady_out); end
      cycle();
    end
    #1;
    n_vec++; if (bus.h2fReady_out !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b want 0", bus.h2fReady_out); end
    bus.h2fValid_in = 1'b0;
    select(7'd9);
    n_vec++; if (bus.f2hData_out !== 8'h10 || bus.f2hValid_out !== 1'b1) begin n_err++; $display("FAIL status_full: got v=%b d=%h want v=1 d=10", bus.f2hValid_out, bus.f2hData_out); end
    select(7'd8);
    // full: pop this cycle, push held off until the next
    bus.h2fData_in  = 8'h10;
    bus.h2fValid_in = 1'b1;
    bus.f2hReady_in = 1'b1;
    #1;
    n_vec++; if (bus.h2fReady_out !== 1'b0 || bus.f2hData_out !== 8'h00) begin n_err++; $display("FAIL full_pop: got r=%b d=%h want r=0 d=00", bus.h2fReady_out, bus.f2hData_out); end
    cycle();
    n_vec++; if (bus.h2fReady_out !== 1'b1 || bus.f2hData_out !== 8'h01) begin n_err++; $display("FAIL after_pop: got r=%b d=%h want r=1 d=01", bus.h2fReady_out, bus.f2hData_out); end
    cycle();
    bus.h2fValid_in = 1'b0;
    for (int i = 2; i <= 16; i++) begin
      #1;
      n_vec++; if (bus.f2hValid_out !== 1'b1 || bus.f2hData_out !== 8'(i)) begin n_err++; $display("FAIL drain[%0d]: got v=%b d=%h want v=1 d=%h", i, bus.f2hValid_out, bus.f2hData_out, 8'(i)); end
      cycle();
    end
    #1;
    n_vec++; if (bus.f2hValid_out !== 1'b0) begin n_err++; $display("FAIL drained: got %b want 0", bus.f2hValid_out); end
    bus.f2hReady_in = 1'b0;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) push(8'(8'h20 + i));
    bus.f2hReady_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_vec++; if (bus.f2hValid_out !== 1'b1 || bus.f2hData_out !== 8'(8'h20 + i)) begin n_err++; $display("FAIL wrap_a[%0d]: got v=%b d=%h", i, bus.f2hValid_out, bus.f2hData_out); end
      cycle();
    end
    bus.f2hReady_in = 1'b0;
    for (int i = 0; i < 12; i++) push(8'(8'h40 + i));
    bus.f2hReady_in = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      n_vec++; if (bus.f2hValid_out !== 1'b1 || bus.f2hData_out !== 8'(8'h40 + i)) begin n_err++; $display("FAIL wrap_b[%0d]: got v=%b d=%h", i, bus.f2hValid_out, bus.f2hData_out); end
      cycle();
    end
    select(7'd9);
    n_vec++; if (bus.f2hData_out !== 8'h00) begin n_err++; $display("FAIL wrap_status: got %h want 00", bus.f2hData_out); end
  endtask

  task automatic test_back_to_back();
    select(7'd8);
    for (int i = 0; i < 5; i++) push(8'(8'h60 + i));
    bus.h2fValid_in = 1'b1;
    bus.f2hReady_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.h2fData_in = 8'(8'h65 + i);
      #1;
      n_vec++; if (bus.f2hValid_out !== 1'b1 || bus.h2fReady_out !== 1'b1 || bus.f2hData_out !== 8'(8'h60 + i)) begin n_err++; $display("FAIL b2b[%0d]: got v=%b r=%b d=%h want d=%h", i, bus.f2hValid_out, bus.h2fReady_out, bus.f2hData_out, 8'(8'h60 + i)); end
      cycle();
    end
    select(7'd9);
    n_vec++; if (bus.f2hData_out !== 8'h05) begin n_err++; $display("FAIL b2b_status: got %h want 05", bus.f2hData_out); end
  endtask

  task automatic test_flush();
    select(7'd8);
    for (int i = 0; i < 7; i++) push(8'(8'h80 + i));
    select(7'd9);
    n_vec++; if (bus.f2hData_out !== 8'h0C) begin n_err++; $display("FAIL pre_flush: got %h want 0c", bus.f2hData_out); end
    push(8'h00);
    n_vec++; if (bus.f2hData_out !== 8'h00) begin n_err++; $display("FAIL post_flush: got %h want 00", bus.f2hData_out); end
    select(7'd8);
    n_vec++; if (bus.f2hValid_out !== 1'b0) begin n_err++; $display("FAIL flush_empty: got %b want 0", bus.f2hValid_out); end
  endtask

  task automatic test_reset_mid();
    select(7'd2);
    push(8'h3C);
    n_vec++; if (regs_out[23:16] !== 8'h3C) begin n_err++; $display("FAIL reg2_wr: got %h want 3c", regs_out[23:16]); end
    select(7'd8);
    for (int i = 0; i < 4; i++) push(8'(8'h90 + i));
    n_vec++; if (bus.f2hValid_out !== 1'b1) begin n_err++; $display("FAIL pre_rst_valid: got %b want 1", bus.f2hValid_out); end
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_vec++; if (regs_out !== 64'h0 || bus.f2hValid_out !== 1'b0 || bus.h2fReady_out !== 1'b0 || bus.f2hData_out !== 8'h00) begin n_err++; $display("FAIL async_rst: got regs=%h v=%b r=%b d=%h want all 0", regs_out, bus.f2hValid_out, bus.h2fReady_out, bus.f2hData_out); end
    #1;
    rst_n = 1'b1;
    #1;
    n_vec++; if (bus.h2fReady_out !== 1'b0) begin n_err++; $display("FAIL rel_blank: got %b want 0", bus.h2fReady_out); end
    cycle();
    n_vec++; if (bus.f2hValid_out !== 1'b0) begin n_err++; $display("FAIL rst_fifo: got %b want 0", bus.f2hValid_out); end
    select(7'd2);
    n_vec++; if (bus.f2hData_out !== 8'h00) begin n_err++; $display("FAIL reg2_rst: got %h want 00", bus.f2hData_out); end
    select(7'd9);
    n_vec++; if (bus.f2hData_out !== 8'h00) begin n_err++; $display("FAIL status_rst: got %h want 00", bus.f2hData_out); end
    select(7'd100);
    n_vec++; if (bus.f2hValid_out !== 1'b0 || bus.h2fReady_out !== 1'b1) begin n_err++; $display("FAIL unmapped: got v=%b r=%b want v=0 r=1", bus.f2hValid_out, bus.h2fReady_out); end
    push(8'h77);
    n_vec++; if (regs_out !== 64'h0) begin n_err++; $display("FAIL unmapped_wr: got %h want 0", regs_out); end
    select(7'd9);
    n_vec++; if (bus.f2hData_out !== 8'h00) begin n_err++; $display("FAIL unmapped_status: got %h want 00", bus.f2hData_out); end
  endtask

  initial begin
    n_vec           = 0;
    n_err           = 0;
    rst_n           = 1'b0;
    bus.chanAddr_in = 7'd3;
    bus.h2fData_in  = 8'h00;
    bus.h2fValid_in = 1'b0;
    bus.f2hReady_in = 1'b0;
    test_reset();
    test_reg_rw();
    test_fifo_fill();
    test_wrap();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fl_chan_regfile.md
Name: fl_chan_regfile

Overview:
- Application-side consumer of the FPGALink channel interface; sits directly downstream of the FX2 comms block.
- Terminates the 7-bit-addressed host-to-FPGA (h2f) and FPGA-to-host (f2h) byte streams.
- Provides NUM_REGS byte registers, one loopback FIFO channel and one status/flush channel.
- Register contents are exported as a flat vector for use by other application logic.

Parameters:
- NUM_REGS, 8, number of byte registers, mapped at channels 0..NUM_REGS-1 (1..64).
- FIFO_DEPTH, 16, loopback FIFO depth in bytes; power of 2, 2..256.
- FIFO_CHAN, 8, channel of the loopback FIFO; must be >= NUM_REGS.
- STATUS_CHAN, 9, status/flush channel; must be distinct from FIFO_CHAN and >= NUM_REGS.

Ports:
- clk_in  in  1  single clock, rising edge.
- reset_in  in  1  asynchronous, active-low reset.
- chanAddr_in  in  7  currently selected channel.
- h2fData_in  in  8  host-to-FPGA byte.
- h2fValid_in  in  1  h2fData_in is valid.
- h2fReady_out  out  1  block accepts h2f byte.
- f2hData_out  out  8  FPGA-to-host byte.
- f2hValid_out  out  1  f2hData_out is valid.
- f2hReady_in  in  1  comms block accepts f2h byte.
- regs_out  out  NUM_REGS*8  register contents; reg k occupies bits [8k+7:8k].

Behaviour:
- Reset (reset_in=0, asynchronous):
  - All registers = 0x00, FIFO empty (rd_ptr = wr_ptr = count = 0), addr_q = 0x7F, blank = 1.
  - h2fReady_out = 0, f2hValid_out = 0, f2hData_out = 0x00, regs_out = 0.
- Write handshake: a write occurs at a rising edge where h2fValid_in=1 and h2fReady_out=1.
- Read handshake: a read occurs at a rising edge where f2hValid_out=1 and f2hReady_in=1.
- Address blanking:
  - addr_q <= chanAddr_in every cycle.
  - blank = (chanAddr_in != addr_q), combinational.
  - While blank=1, h2fReady_out = 0 and f2hValid_out = 0, so the first cycle on any newly selected channel never handshakes.
- h2fReady_out when not blank and out of reset:
  - register channel: 1.
  - FIFO_CHAN: 1 when count < FIFO_DEPTH.
  - STATUS_CHAN: 1.
  - unmapped channel: 1 (byte discarded).
- Writes:
  - register k: reg[k] <= h2fData_in, visible on regs_out the next cycle.
  - FIFO_CHAN: mem[wr_ptr] <= data, wr_ptr wraps modulo FIFO_DEPTH, count+1.
  - STATUS_CHAN: any value flushes the FIFO (rd_ptr = wr_ptr = count = 0); the data byte is ignored.
- f2h path when not blank (combinational from registered state):
  - register k: data = reg[k], valid = 1; a read has no side effect.
  - FIFO_CHAN: data = mem[rd_ptr], valid = (count != 0); a read advances rd_ptr (wrap) and decrements count.
  - STATUS_CHAN: data = min(count, 255), valid = 1.
  - unmapped channel: data = 0x00, valid = 0.
- Simultaneous events:
  - Write and read on the same register in one cycle: the read returns the pre-write value; the new value appears from the next cycle.
  - FIFO push and pop in one cycle (count between 1 and FIFO_DEPTH-1): count unchanged, both pointers advance.
  - FIFO full: h2fReady_out = 0 even if a pop occurs in the same cycle; the push is accepted on the following cycle.
  - FIFO empty: f2hValid_out = 0; a push that cycle makes data valid next cycle (1-cycle write-to-read latency).
- count width is clog2(FIFO_DEPTH)+1; count never exceeds FIFO_DEPTH and never underflows.
- Reset asserted mid-transfer: FIFO contents are lost and registers are cleared immediately. After release, addr_q = 0x7F, so the first cycle is always blanked.

Test Plan:
- Register write/read: release reset with chanAddr=3. Cycle 1 shows h2fReady=0 (blank). Write 0xA5 → regs_out[31:24]=0xA5. Read on chan 3 → f2hData=0xA5, valid=1.
- FIFO fill/drain: on chan 8, push 16 bytes 0x00..0x0F → h2fReady drops to 0 after the 16th byte. Chan 9 reads 0x10. Chan 8 reads return 0x00..0x0F in order, then f2hValid=0.
- Wrap-around: push 10, pop 10, push 12, pop 12 → data intact across the pointer wrap; status reads 0 at the end.
- Simultaneous push/pop with count=5 for 20 cycles → status stays 5; output order is preserved.
- Flush: push 7 bytes, then write 0x00 to chan 9 → status reads 0; a chan 8 read shows f2hValid=0.
- Reset mid-operation: reg2=0x3C and FIFO count 4, then pulse reset_in low asynchronously between edges → immediately all outputs are 0. After release, reg2 reads 0x00 and status reads 0. Unmapped chan 100 gives f2hValid=0 and accepts writes with no effect.
